// File: rtl/forthsuper_pkg.sv
// Shared types and constants for the dictionary header writer.
package forthsuper_pkg;

  typedef enum logic [2:0] {IDL, RD, CW, LEN, LF0, LF1, FIN} creator_sts;

  localparam logic [16:0] DIC_END = 17'h0ffff;
  localparam logic [7:0]  CH_SPC  = 8'h20;

endpackage

// File: rtl/word_creator_if.sv
// Single-port memory master bus: address, write data, write enable.
interface mb8_io #(
  parameter int unsigned ASZ = 17,
  parameter int unsigned DSZ = 8
);
  logic [ASZ-1:0] ai;
  logic [DSZ-1:0] vi;
  logic           we;

  modport master (output ai, output vi, output we);
  modport slave  (input  ai, input  vi, input  we);
endinterface

// File: rtl/word_creator.sv
// Parses the next blank-delimited TIB token and appends a dictionary header
// [lfa lo][lfa hi][len][name] at HERE, then publishes the new context/HERE.
module word_creator
  import forthsuper_pkg::*;
#(
  parameter int unsigned DSZ  = 8,
  parameter int unsigned ASZ  = 17,
  parameter int unsigned NMAX = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  mb8_io.master          mb_if,
  input  logic           en,
  input  logic [ASZ-1:0] aw,
  input  logic [ASZ-1:0] ctx,
  input  logic [ASZ-1:0] here,
  input  logic [DSZ-1:0] vw,
  output logic           bsy,
  output logic           ok,
  output logic           err,
  output logic [ASZ-1:0] tib,
  output logic [ASZ-1:0] ctx_o,
  output logic [ASZ-1:0] here_o
);

  localparam int unsigned LW = $clog2(NMAX + 1);

  creator_sts     st, st_n;
  logic [ASZ-1:0] a1;
  logic [LW-1:0]  len;
  logic           is_nul, is_spc, is_delim, len_zero, len_max, name_wr;
  logic [ASZ-1:0] name_addr;
  logic           unused_ctx_hi;

  assign is_nul    = (vw == '0);
  assign is_spc    = (vw == DSZ'(CH_SPC));
  assign is_delim  = is_nul | is_spc;
  assign len_zero  = (len == '0);
  assign len_max   = (len == LW'(NMAX));
  assign name_wr   = !is_delim && !len_max;
  assign name_addr = here + ASZ'(3) + ASZ'(len);

  // Headers live in the low 64K, so only ctx[15:0] goes into the link field.
  assign unused_ctx_hi = ^ctx[ASZ-1:16];

  always_comb begin
    st_n = st;
    if (!en) begin
      st_n = IDL;
    end else begin
      case (st)
        IDL: st_n = RD;
        RD:  st_n = CW;
        CW: begin
          if (is_spc && len_zero)        st_n = RD;
          else if (is_delim && !len_zero) st_n = LEN;
          else if (is_delim)              st_n = FIN;
          else if (len_max)               st_n = FIN;
          else                            st_n = RD;
        end
        LEN:     st_n = LF0;
        LF0:     st_n = LF1;
        LF1:     st_n = FIN;
        FIN:     st_n = FIN;
        default: st_n = IDL;
      endcase
    end
  end

  always_comb begin
    mb_if.ai = aw;
    mb_if.vi = '0;
    mb_if.we = 1'b0;
    case (st)
      RD: mb_if.ai = a1;
      CW: begin
        mb_if.ai = a1;
        if (name_wr) begin
          mb_if.ai = name_addr;
          mb_if.vi = vw;
          mb_if.we = 1'b1;
        end
      end
      LEN: begin
        mb_if.ai = here + ASZ'(2);
        mb_if.vi = DSZ'(len);
        mb_if.we = 1'b1;
      end
      LF0: begin
        mb_if.ai = here;
        mb_if.vi = DSZ'(ctx[7:0]);
        mb_if.we = 1'b1;
      end
      LF1: begin
        mb_if.ai = here + ASZ'(1);
        mb_if.vi = DSZ'(ctx[15:8]);
        mb_if.we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDL;
    else        st <= st_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1     <= '0;
      len    <= '0;
      bsy    <= 1'b0;
      ok     <= 1'b0;
      err    <= 1'b0;
      tib    <= '0;
      ctx_o  <= ASZ'(DIC_END);
      here_o <= '0;
    end else if (!en) begin
      bsy <= 1'b0;
    end else begin
      case (st)
        IDL: begin
          a1  <= aw;
          len <= '0;
          ok  <= 1'b0;
          err <= 1'b0;
          bsy <= 1'b1;
        end
        CW: begin
          if (is_delim && len_zero && !is_spc) begin
            err <= 1'b1;
          end else if (!is_delim && len_max) begin
            err <= 1'b1;
          end else begin
            a1 <= a1 + 1'b1;
            if (!is_delim) len <= len + 1'b1;
          end
        end
        LF1: ok <= 1'b1;
        FIN: begin
          bsy <= 1'b0;
          tib <= a1;
          if (ok) begin
            ctx_o  <= here;
            here_o <= name_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_word_creator.sv
// Directed bench for word_creator with a registered-read byte memory model.
module tb_word_creator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [16:0] aw = '0, ctx = '0, here = '0;
  logic [7:0]  vw;
  logic        bsy, ok, err;
  logic [16:0] tib, ctx_o, here_o;

  logic [7:0]  mem [0:131071];
  logic        ld_en = 1'b0;
  logic [16:0] ld_a = '0;
  logic [7:0]  ld_d = '0;
  int          wcnt = 0;
  int          tests = 0;
  int          fails = 0;

  mb8_io #(.ASZ(17), .DSZ(8)) mb ();

  word_creator #(.DSZ(8), .ASZ(17), .NMAX(31)) dut (
    .clk(clk), .rst_n(rst_n), .mb_if(mb), .en(en), .aw(aw), .ctx(ctx),
    .here(here), .vw(vw), .bsy(bsy), .ok(ok), .err(err), .tib(tib),
    .ctx_o(ctx_o), .here_o(here_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (mb.we) begin
      mem[mb.ai] <= mb.vi;
      wcnt <= wcnt + 1;
    end
    vw <= mem[mb.ai];
  end

  typedef struct {
    logic [63:0] txt;
    int          n;
    logic [16:0] c, h;
    logic        eok, eerr;
    logic [16:0] etib, ectx, ehere;
    int          elat;
  } vec_t;

  vec_t v [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic create(input logic [16:0] a, input logic [16:0] c,
                        input logic [16:0] h, output int lat);
    aw = a; ctx = c; here = h; en = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(ok || err) && lat < 400);
    if (lat >= 400) chk("timeout", 32'(lat), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic release_en();
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat, w0, idx, nl, hops;
    logic [7:0]  b;
    logic [7:0]  nm [32];
    logic [16:0] p, la;

    v[0] = '{64'h44555020, 4, 17'h00080, 17'h00100, 1, 0, 17'h14, 17'h00100, 17'h00106, 11};
    v[1] = '{64'h20202B00, 4, 17'h00100, 17'h00200, 1, 0, 17'h14, 17'h00200, 17'h00204, 11};
    v[2] = '{64'h00,       1, 17'h00200, 17'h00300, 0, 1, 17'h10, 17'h00200, 17'h00204, 2};
    v[3] = '{64'h414200,   3, 17'h1ABCD, 17'h00300, 1, 0, 17'h13, 17'h00300, 17'h00305, 9};
    v[4] = '{64'h20202000, 4, 17'h00300, 17'h00400, 0, 1, 17'h13, 17'h00300, 17'h00305, 8};
    v[5] = '{64'h5800,     2, 17'h00400, 17'h1FFFE, 1, 0, 17'h12, 17'h1FFFE, 17'h00002, 7};

    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_bsy", 32'(bsy), 0);
    chk("rst_ok", 32'(ok), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_tib", 32'(tib), 0);
    chk("rst_ctx_o", 32'(ctx_o), 32'h0ffff);
    chk("rst_here_o", 32'(here_o), 0);
    chk("rst_we", 32'(mb.we), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < v[k].n; i++)
        poke(17'h10 + 17'(i), v[k].txt[8*(v[k].n-1-i) +: 8]);
      w0 = wcnt;
      create(17'h10, v[k].c, v[k].h, lat);
      chk($sformatf("v%0d_ok", k), 32'(ok), 32'(v[k].eok));
      chk($sformatf("v%0d_err", k), 32'(err), 32'(v[k].eerr));
      chk($sformatf("v%0d_bsy", k), 32'(bsy), 0);
      chk($sformatf("v%0d_tib", k), 32'(tib), 32'(v[k].etib));
      chk($sformatf("v%0d_ctx_o", k), 32'(ctx_o), 32'(v[k].ectx));
      chk($sformatf("v%0d_here_o", k), 32'(here_o), 32'(v[k].ehere));
      chk($sformatf("v%0d_lat", k), 32'(lat), 32'(v[k].elat));
      idx = 0; nl = 0;
      while (idx < v[k].n && v[k].txt[8*(v[k].n-1-idx) +: 8] == 8'h20) idx++;
      while (idx < v[k].n) begin
        b = v[k].txt[8*(v[k].n-1-idx) +: 8];
        if (b == 8'h20 || b == 8'h00) break;
        nm[nl] = b; nl++; idx++;
      end
      if (v[k].eok) begin
        la = v[k].h;
        chk($sformatf("v%0d_lfa_lo", k), 32'(mem[la]), 32'(v[k].c[7:0]));
        la = v[k].h + 17'd1;
        chk($sformatf("v%0d_lfa_hi", k), 32'(mem[la]), 32'(v[k].c[15:8]));
        la = v[k].h + 17'd2;
        chk($sformatf("v%0d_len", k), 32'(mem[la]), 32'(nl));
        for (int i = 0; i < nl; i++) begin
          la = v[k].h + 17'd3 + 17'(i);
          chk($sformatf("v%0d_name%0d", k, i), 32'(mem[la]), 32'(nm[i]));
        end
        chk($sformatf("v%0d_wcnt", k), 32'(wcnt - w0), 32'(nl + 3));
      end else begin
        chk($sformatf("v%0d_wcnt", k), 32'(wcnt - w0), 0);
      end
      release_en();
    end

    // 31-char name is the longest accepted; 32 chars flags err at the 32nd
    for (int i = 0; i < 31; i++) poke(17'h10 + 17'(i), 8'h61);
    poke(17'h2F, 8'h20);
    create(17'h10, 17'h01234, 17'h00500, lat);
    chk("n31_ok", 32'(ok), 1);
    chk("n31_lat", 32'(lat), 67);
    chk("n31_tib", 32'(tib), 32'h30);
    chk("n31_here_o", 32'(here_o), 32'h522);
    chk("n31_len", 32'(mem[17'h502]), 31);
    release_en();
    poke(17'h2F, 8'h61);
    poke(17'h30, 8'h20);
    w0 = wcnt;
    create(17'h10, 17'h00500, 17'h00600, lat);
    chk("n32_err", 32'(err), 1);
    chk("n32_ok", 32'(ok), 0);
    chk("n32_lat", 32'(lat), 64);
    chk("n32_tib", 32'(tib), 32'h2F);
    chk("n32_ctx_o", 32'(ctx_o), 32'h500);
    chk("n32_here_o", 32'(here_o), 32'h522);
    chk("n32_wcnt", 32'(wcnt - w0), 31);
    release_en();

    // async reset while in CW
    poke(17'h10, 8'h44); poke(17'h11, 8'h55); poke(17'h12, 8'h50); poke(17'h13, 8'h20);
    aw = 17'h10; ctx = 17'h80; here = 17'h600; en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("arst_bsy", 32'(bsy), 0);
    chk("arst_ctx_o", 32'(ctx_o), 32'h0ffff);
    chk("arst_we", 32'(mb.we), 0);
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // en dropped mid-name
    en = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    chk("abort_bsy", 32'(bsy), 0);
    chk("abort_we", 32'(mb.we), 0);
    chk("abort_ai", 32'(mb.ai), 32'h10);
    @(posedge clk); @(posedge clk); #1;
    chk("abort_ctx_o", 32'(ctx_o), 32'h0ffff);
    chk("abort_here_o", 32'(here_o), 0);

    // chained headers, then walk the link chain looking for "A"
    poke(17'h10, 8'h41); poke(17'h11, 8'h20);
    create(17'h10, 17'h0ffff, 17'h00700, lat);
    chk("chA_here_o", 32'(here_o), 32'h704);
    release_en();
    poke(17'h10, 8'h42);
    create(17'h10, 17'h00700, 17'h00704, lat);
    chk("chB_ctx_o", 32'(ctx_o), 32'h704);
    chk("chB_here_o", 32'(here_o), 32'h708);
    release_en();
    chk("chB_link", 32'({mem[17'h705], mem[17'h704]}), 32'h700);
    p = 17'h704; hops = 0;
    while (p != 17'h0ffff && hops < 8) begin
      la = p + 17'd2;
      if (mem[la] == 8'd1) begin
        la = p + 17'd3;
        if (mem[la] == 8'h41) break;
      end
      la = p + 17'd1;
      p = {1'b0, mem[la], mem[p]};
      hops++;
    end
    chk("find_A", 32'(p), 32'h700);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
